cam_access_controller: RTL and testbench

Sequencer and two-port arbiter in front of the 16-entry x 8-bit content-addressable memory (CAM). It initialises every CAM slot to an empty marker after reset. It round-robin arbitrates lookup and write requests from two requesters and drives the CAM's wen/ren/din/addr pins. On a lookup miss it can optionally "learn" the key into a FIFO-replaced slot, returning hit, index and status through a req/ack handshake.

---
 rtl/cam_access_controller.sv | 255 +++++++++++++++++++++++++
 tb/tb_cam_access_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cam_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : cam_access_controller
// Purpose  : Sequencer and two-port round-robin arbiter in front of a
//            16-entry x 8-bit CAM. After reset it sweeps every slot to
//            EMPTY_KEY, then serves lookup / write requests from two
//            requesters, optionally learning missed keys into a FIFO-replaced
//            slot, and reports results through a req/ack handshake.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req/op/learn [1:0]  - per-requester request, opcode, learn flag
//            key0/key1, waddr0/waddr1 - per-requester operands
//            ack [1:0]           - one-cycle completion pulse
//            rsp_hit/index/learned/err - transaction result, held until next
//            busy, full          - controller not idle / learn area full
//            cam_wen/ren/din/addr - CAM control pins
//            cam_dout, cam_hit   - CAM registered index / live hit
// Revision : 1.0 - initial release
// ============================================================================
module cam_access_controller #(
    parameter logic [7:0] EMPTY_KEY = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] op,
    input  logic [1:0] learn,
    input  logic [7:0] key0,
    input  logic [7:0] key1,
    input  logic [3:0] waddr0,
    input  logic [3:0] waddr1,
    output logic [1:0] ack,
    output logic       rsp_hit,
    output logic [3:0] rsp_index,
    output logic       rsp_learned,
    output logic       rsp_err,
    output logic       busy,
    output logic       full,
    output logic       cam_wen,
    output logic       cam_ren,
    output logic [7:0] cam_din,
    output logic [3:0] cam_addr,
    input  logic [3:0] cam_dout,
    input  logic       cam_hit
);

    localparam logic [3:0] C_LAST_SLOT = 4'd15;
    localparam logic [4:0] C_FULL_OCC  = 5'd16;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_LOOKUP = 3'd2,
        S_RESP   = 3'd3,
        S_INSERT = 3'd4,
        S_WRITE  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] init_ptr_q, init_ptr_d;
    logic [3:0] fill_ptr_q, fill_ptr_d;
    logic [4:0] occ_q, occ_d;
    logic       last_grant_q, last_grant_d;
    logic       grant_q, grant_d;
    logic       learn_q, learn_d;
    logic [7:0] key_q, key_d;
    logic [3:0] waddr_q, waddr_d;
    logic       hit_q, hit_d;
    logic [1:0] ack_q, ack_d;
    logic       rsp_hit_q, rsp_hit_d;
    logic [3:0] rsp_index_q, rsp_index_d;
    logic       rsp_learned_q, rsp_learned_d;
    logic       rsp_err_q, rsp_err_d;

    // Arbitration: on a tie the requester not served last wins.
    logic       w_sel;
    logic [7:0] w_sel_key;
    logic [3:0] w_sel_waddr;

    always_comb begin
        w_sel       = (req == 2'b11) ? ~last_grant_q : req[1];
        w_sel_key   = w_sel ? key1 : key0;
        w_sel_waddr = w_sel ? waddr1 : waddr0;
    end

    always_comb begin
        state_d       = state_q;
        init_ptr_d    = init_ptr_q;
        fill_ptr_d    = fill_ptr_q;
        occ_d         = occ_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        learn_d       = learn_q;
        key_d         = key_q;
        waddr_d       = waddr_q;
        hit_d         = hit_q;
        ack_d         = 2'b00;
        rsp_hit_d     = rsp_hit_q;
        rsp_index_d   = rsp_index_q;
        rsp_learned_d = rsp_learned_q;
        rsp_err_d     = rsp_err_q;

        case (state_q)
            S_INIT: begin
                init_ptr_d = init_ptr_q + 4'd1;
                if (init_ptr_q == C_LAST_SLOT) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (|req) begin
                    grant_d      = w_sel;
                    last_grant_d = w_sel;
                    learn_d      = learn[w_sel];
                    key_d        = w_sel_key;
                    waddr_d      = w_sel_waddr;
                    if (w_sel_key == EMPTY_KEY) begin
                        // Rejected without touching the CAM: the empty
                        // marker would match every unused slot.
                        state_d       = S_DONE;
                        ack_d         = w_sel ? 2'b10 : 2'b01;
                        rsp_hit_d     = 1'b0;
                        rsp_index_d   = 4'd0;
                        rsp_learned_d = 1'b0;
                        rsp_err_d     = 1'b1;
                    end else if (op[w_sel]) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                hit_d   = cam_hit;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (!hit_q && learn_q) begin
                    state_d = S_INSERT;
                end else begin
                    // cam_dout was registered by the CAM during LOOKUP.
                    state_d       = S_DONE;
                    ack_d         = grant_q ? 2'b10 : 2'b01;
                    rsp_hit_d     = hit_q;
                    rsp_index_d   = hit_q ? cam_dout : 4'd0;
                    rsp_learned_d = 1'b0;
                    rsp_err_d     = 1'b0;
                end
            end
            S_INSERT: begin
                fill_ptr_d    = fill_ptr_q + 4'd1;
                occ_d         = (occ_q == C_FULL_OCC) ? C_FULL_OCC : occ_q + 5'd1;
                state_d       = S_DONE;
                ack_d         = grant_q ? 2'b10 : 2'b01;
                rsp_hit_d     = 1'b0;
                rsp_index_d   = fill_ptr_q;
                rsp_learned_d = 1'b1;
                rsp_err_d     = 1'b0;
            end
            S_WRITE: begin
                state_d       = S_DONE;
                ack_d         = grant_q ? 2'b10 : 2'b01;
                rsp_hit_d     = 1'b0;
                rsp_index_d   = 4'd0;
                rsp_learned_d = 1'b0;
                rsp_err_d     = 1'b0;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_INIT;
            init_ptr_q    <= 4'd0;
            fill_ptr_q    <= 4'd0;
            occ_q         <= 5'd0;
            last_grant_q  <= 1'b1;
            grant_q       <= 1'b0;
            learn_q       <= 1'b0;
            key_q         <= 8'd0;
            waddr_q       <= 4'd0;
            hit_q         <= 1'b0;
            ack_q         <= 2'b00;
            rsp_hit_q     <= 1'b0;
            rsp_index_q   <= 4'd0;
            rsp_learned_q <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_ptr_q    <= init_ptr_d;
            fill_ptr_q    <= fill_ptr_d;
            occ_q         <= occ_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            learn_q       <= learn_d;
            key_q         <= key_d;
            waddr_q       <= waddr_d;
            hit_q         <= hit_d;
            ack_q         <= ack_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_index_q   <= rsp_index_d;
            rsp_learned_q <= rsp_learned_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    // CAM pins decode the current state. Enables are masked by rst so the
    // CAM is never written while reset is held, even though state is INIT.
    always_comb begin
        cam_wen  = 1'b0;
        cam_ren  = 1'b0;
        cam_din  = 8'd0;
        cam_addr = 4'd0;
        case (state_q)
            S_INIT: begin
                cam_wen  = ~rst;
                cam_din  = EMPTY_KEY;
                cam_addr = init_ptr_q;
            end
            S_LOOKUP: begin
                cam_ren = ~rst;
                cam_din = key_q;
            end
            S_INSERT: begin
                cam_wen  = ~rst;
                cam_din  = key_q;
                cam_addr = fill_ptr_q;
            end
            S_WRITE: begin
                cam_wen  = ~rst;
                cam_din  = key_q;
                cam_addr = waddr_q;
            end
            default: begin
                cam_wen  = 1'b0;
            end
        endcase
    end

    assign ack         = ack_q;
    assign rsp_hit     = rsp_hit_q;
    assign rsp_index   = rsp_index_q;
    assign rsp_learned = rsp_learned_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = (state_q != S_IDLE);
    assign full        = (occ_q == C_FULL_OCC);

endmodule
`default_nettype wire

// File: tb/tb_cam_access_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cam_access_controller
// Purpose  : Directed self-checking bench for cam_access_controller with a
//            behavioural 16x8 CAM attached to the CAM pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_access_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req, op, learn;
    logic [7:0] key0, key1;
    logic [3:0] waddr0, waddr1;
    logic [1:0] ack;
    logic       rsp_hit, rsp_learned, rsp_err, busy, full;
    logic [3:0] rsp_index;
    logic       cam_wen, cam_ren, cam_hit;
    logic [7:0] cam_din;
    logic [3:0] cam_addr, cam_dout;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    cam_access_controller dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .learn(learn),
        .key0(key0), .key1(key1), .waddr0(waddr0), .waddr1(waddr1),
        .ack(ack), .rsp_hit(rsp_hit), .rsp_index(rsp_index),
        .rsp_learned(rsp_learned), .rsp_err(rsp_err), .busy(busy), .full(full),
        .cam_wen(cam_wen), .cam_ren(cam_ren), .cam_din(cam_din),
        .cam_addr(cam_addr), .cam_dout(cam_dout), .cam_hit(cam_hit)
    );

    // Behavioural CAM: lowest index wins, index registered on read.
    logic [7:0] mem [16];

    function automatic logic [3:0] match_idx(input logic [7:0] k);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) if (mem[i] == k) r = i[3:0];
        return r;
    endfunction

    always_comb begin
        cam_hit = 1'b0;
        if (cam_ren) for (int i = 0; i < 16; i++) if (mem[i] == cam_din) cam_hit = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (cam_wen) mem[cam_addr] <= cam_din;
        if (cam_ren) cam_dout <= match_idx(cam_din);
    end

    logic excl_bad = 1'b0;
    logic ack_both = 1'b0;
    always @(negedge clk) begin
        if (cam_wen && cam_ren) excl_bad = 1'b1;
        if (ack == 2'b11)       ack_both = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 2'b00;
        repeat (2) begin
            @(negedge clk);
            chk("rst_wen", cam_wen, 0);
            chk("rst_ren", cam_ren, 0);
            chk("rst_busy", busy, 1);
            chk("rst_ack", ack, 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Cycle k is the k-th cycle after the last edge that sampled rst high.
    task automatic init_check();
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk("init_wen", cam_wen, (k <= 16));
            chk("init_ren", cam_ren, 0);
            if (k <= 16) begin
                chk("init_addr", cam_addr, k - 1);
                chk("init_din", cam_din, 8'hFF);
            end
            chk("init_busy", busy, (k <= 16));
            chk("init_ack", ack, 0);
        end
        chk("init_rsp", {rsp_hit, rsp_index, rsp_learned, rsp_err}, 0);
        chk("init_full", full, 0);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("idle_seen", busy, 0);
    endtask

    // Issue one request from requester r and run it to its ack.
    task automatic txn(input string name, input int r, input logic o, input logic l,
                       input logic [7:0] k, input logic [3:0] wa,
                       input int e_lat, input logic e_hit, input logic [3:0] e_idx,
                       input logic e_ln, input logic e_err, output logic acc);
        int lat;
        wait_idle();
        if (r == 0) begin op[0] = o; learn[0] = l; key0 = k; waddr0 = wa; end
        else        begin op[1] = o; learn[1] = l; key1 = k; waddr1 = wa; end
        req[r] = 1'b1;
        lat = 0;
        acc = 1'b0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            acc = acc | cam_wen | cam_ren;
            if (ack[r]) lat = c;
        end
        req[r] = 1'b0;
        chk({name, "_lat"}, lat, e_lat);
        chk({name, "_hit"}, rsp_hit, e_hit);
        chk({name, "_idx"}, rsp_index, e_idx);
        chk({name, "_learned"}, rsp_learned, e_ln);
        chk({name, "_err"}, rsp_err, e_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic acc;
        int   nack, last_t, t;
        rst = 1'b1; req = 2'b00; op = 2'b00; learn = 2'b00;
        key0 = 8'd0; key1 = 8'd0; waddr0 = 4'd0; waddr1 = 4'd0;

        do_reset();
        init_check();

        // Write then lookup from requester 0.
        txn("wr3c", 0, 1'b1, 1'b0, 8'h3C, 4'd5, 2, 1'b0, 4'd0, 1'b0, 1'b0, acc);
        chk("wr3c_acc", acc, 1);
        txn("lk3c", 0, 1'b0, 1'b0, 8'h3C, 4'd0, 3, 1'b1, 4'd5, 1'b0, 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        chk("rsp_hold_idx", rsp_index, 5);
        chk("ack_pulse", ack, 0);

        // Learn on miss from requester 1, then hit.
        txn("ln77", 1, 1'b0, 1'b1, 8'h77, 4'd0, 4, 1'b0, 4'd0, 1'b1, 1'b0, acc);
        txn("lk77", 1, 1'b0, 1'b0, 8'h77, 4'd0, 3, 1'b1, 4'd0, 1'b0, 1'b0, acc);

        // Both requesters hold lookups: grants alternate starting with 0.
        wait_idle();
        op = 2'b00; learn = 2'b00; key0 = 8'h3C; key1 = 8'h77;
        req = 2'b11;
        nack = 0; last_t = 0;
        for (t = 1; t <= 40 && nack < 4; t++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                chk("rr_ack", ack, (nack % 2 == 1) ? 2'b10 : 2'b01);
                chk("rr_hit", rsp_hit, 1);
                chk("rr_idx", rsp_index, (nack % 2 == 1) ? 0 : 5);
                if (nack > 0) chk("rr_gap", t - last_t, 4);
                last_t = t;
                nack++;
                if (nack == 4) req = 2'b00;
            end
        end
        req = 2'b00;
        chk("rr_count", nack, 4);

        // Empty-marker key is rejected without a CAM access.
        txn("rej", 0, 1'b0, 1'b0, 8'hFF, 4'd0, 1, 1'b0, 4'd0, 1'b0, 1'b1, acc);
        chk("rej_acc", acc, 0);

        // Reset in the middle of a lookup.
        wait_idle();
        op[0] = 1'b0; learn[0] = 1'b0; key0 = 8'h3C; req = 2'b01;
        t = 0;
        while (!cam_ren && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("mid_lookup_seen", cam_ren, 1);
        do_reset();
        init_check();

        // 17 learns fill all 16 slots and wrap to slot 0.
        for (int i = 0; i < 17; i++) begin
            logic [7:0] kk;
            kk = 8'h10 + i[7:0];
            txn("fill", 0, 1'b0, 1'b1, kk, 4'd0, 4, 1'b0, i[3:0], 1'b1, 1'b0, acc);
            chk("fill_full", full, (i >= 15));
        end
        txn("lk10", 0, 1'b0, 1'b0, 8'h10, 4'd0, 3, 1'b0, 4'd0, 1'b0, 1'b0, acc);
        txn("lk20", 1, 1'b0, 1'b0, 8'h20, 4'd0, 3, 1'b1, 4'd0, 1'b0, 1'b0, acc);
        txn("lk1f", 0, 1'b0, 1'b0, 8'h1F, 4'd0, 3, 1'b1, 4'd15, 1'b0, 1'b0, acc);

        // A write into a learned slot replaces it.
        txn("wr_over", 1, 1'b1, 1'b0, 8'h5A, 4'd3, 2, 1'b0, 4'd0, 1'b0, 1'b0, acc);
        txn("lk5a", 0, 1'b0, 1'b0, 8'h5A, 4'd0, 3, 1'b1, 4'd3, 1'b0, 1'b0, acc);
        txn("lk13", 0, 1'b0, 1'b0, 8'h13, 4'd0, 3, 1'b0, 4'd0, 1'b0, 1'b0, acc);

        chk("wen_ren_exclusive", excl_bad, 0);
        chk("ack_exclusive", ack_both, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
